// File: rtl/byte_serial_subtractor_if.sv
// rtl/byte_serial_subtractor_if.sv - operand/result handshake bundle for byte_serial_subtractor
interface byte_serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, data_a, data_b, out_ready,
    input  in_ready, out_valid, result, borrow_out, overflow, zero
  );

  modport slave (
    input  in_valid, data_a, data_b, out_ready,
    output in_ready, out_valid, result, borrow_out, overflow, zero
  );
endinterface

// File: rtl/byte_serial_subtractor.sv
// rtl/byte_serial_subtractor.sv - multi-cycle a-b using one 8-bit a+~b+carry stage per clock
module byte_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input logic                    clock,
  input logic                    reset,
  byte_serial_subtractor_if.slave bus
);
  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_nb;
  logic [WIDTH-1:0] res_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             borrow_r;
  logic             ovf_r;
  logic             zero_r;

  logic [7:0]       a_byte;
  logic [7:0]       nb_byte;
  logic [8:0]       sum;
  logic [WIDTH-1:0] next_res;
  logic             last;

  // The subtrahend is inverted at accept time, so the byte stage is a plain adder.
  always_comb begin
    a_byte   = op_a[{idx, 3'b000} +: 8];
    nb_byte  = op_nb[{idx, 3'b000} +: 8];
    sum      = {1'b0, a_byte} + {1'b0, nb_byte} + {8'b0, carry};
    next_res = res_r;
    next_res[{idx, 3'b000} +: 8] = sum[7:0];
    last     = (idx == IW'(NB - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_nb       <= '0;
      res_r       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      borrow_r    <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            op_a       <= bus.data_a;
            op_nb      <= ~bus.data_b;
            carry      <= 1'b1;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          res_r <= next_res;
          carry <= sum[8];
          idx   <= idx + IW'(1);
          // Flags come from the fully assembled result on the final byte edge.
          if (last) begin
            borrow_r    <= ~sum[8];
            ovf_r       <= (op_a[WIDTH-1] == op_nb[WIDTH-1]) &&
                           (next_res[WIDTH-1] != op_a[WIDTH-1]);
            zero_r      <= (next_res == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.result     = res_r;
  assign bus.borrow_out = borrow_r;
  assign bus.overflow   = ovf_r;
  assign bus.zero       = zero_r;
endmodule

// File: tb/tb_byte_serial_subtractor.sv
// tb/tb_byte_serial_subtractor.sv - randomized model-checked bench for byte_serial_subtractor
module tb_byte_serial_subtractor;
  localparam int WIDTH = 32;
  localparam int NB    = WIDTH / 8;

  typedef struct packed {
    logic [31:0] res;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t cur_exp;
  bit   have_exp = 1'b0;

  always #5 clk = ~clk;

  byte_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  byte_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint sd;
    longint lim;
    lim      = 64'sh7FFF_FFFF;
    sa       = longint'($signed(a));
    sb       = longint'($signed(b));
    sd       = sa - sb;
    e.res    = a - b;
    e.borrow = (a < b);
    e.ovf    = (sd > lim) || (sd < -lim - 1);
    e.zero   = (e.res == 32'h0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (!have_exp) chk("unexpected_out_valid", 32'(bus.out_valid), 32'h0);
      else begin
        chk("result", bus.result, cur_exp.res);
        chk("borrow", 32'(bus.borrow_out), 32'(cur_exp.borrow));
        chk("overflow", 32'(bus.overflow), 32'(cur_exp.ovf));
        chk("zero", 32'(bus.zero), 32'(cur_exp.zero));
        chk("in_ready_in_done", 32'(bus.in_ready), 32'h0);
      end
    end
  end

  // Starts and ends just after a falling edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        output exp_t got);
    int n;
    int lat;
    got = '0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'h0, 32'h1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.data_a   = a;
    bus.data_b   = b;
    @(posedge clk);
    cur_exp  = model(a, b);
    have_exp = 1'b1;
    #1;
    bus.data_a   = $urandom;
    bus.data_b   = $urandom;
    bus.in_valid = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.data_a   = $urandom;
      bus.data_b   = $urandom;
      bus.in_valid = 1'($urandom_range(0, 1));
    end while (!bus.out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(NB));
    got = {bus.result, bus.borrow_out, bus.overflow, bus.zero};
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.data_a   = $urandom;
      bus.data_b   = $urandom;
      @(negedge clk);
      chk("hold_result_stable", bus.result, got.res);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    have_exp = 1'b0;
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_pop", 32'(bus.out_valid), 32'h0);
    chk("in_ready_after_pop", 32'(bus.in_ready), 32'h1);
  endtask

  initial begin
    exp_t        g;
    exp_t        m;
    logic [31:0] ra;
    logic [31:0] rb;

    m = model(32'h5, 32'h3);
    chk("model_pin_sub", m.res, 32'h2);
    m = model(32'h8000_0000, 32'h1);
    chk("model_pin_ovf", 32'(m.ovf), 32'h1);
    m = model(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk("model_pin_ovf2", {m.res[31:2], m.borrow, m.ovf}, {30'h2000_0000, 2'b11});

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags", {29'h0, bus.borrow_out, bus.overflow, bus.zero}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'h0000_0005, 32'h0000_0003, 0, g);
    chk("t1_result", g.res, 32'h0000_0002);
    chk("t1_flags", {29'h0, g.borrow, g.ovf, g.zero}, 32'h0);
    run_op(32'h0000_00FF, 32'h0000_0100, 0, g);
    chk("t2_result", g.res, 32'hFFFF_FFFF);
    chk("t2_flags", {29'h0, g.borrow, g.ovf, g.zero}, 32'h4);
    run_op(32'h8000_0000, 32'h0000_0001, 1, g);
    chk("t3a_result", g.res, 32'h7FFF_FFFF);
    chk("t3a_flags", {29'h0, g.borrow, g.ovf, g.zero}, 32'h2);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, g);
    chk("t3b_result", g.res, 32'h8000_0000);
    chk("t3b_flags", {29'h0, g.borrow, g.ovf, g.zero}, 32'h6);
    run_op(32'h1234_5678, 32'h1234_5678, 0, g);
    chk("t4_result", g.res, 32'h0);
    chk("t4_flags", {29'h0, g.borrow, g.ovf, g.zero}, 32'h1);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 10, g);
    chk("t5_result", g.res, 32'hD2FF_CEE2);
    run_op(32'h0000_0010, 32'h0000_0001, 0, g);
    chk("t5_next_result", g.res, 32'h0000_000F);

    // Abort on the second RUN cycle.
    bus.in_valid = 1'b1;
    bus.data_a   = 32'h0001_1111;
    bus.data_b   = 32'h0000_0022;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_result", bus.result, 32'h0);
    chk("abort_flags", {29'h0, bus.borrow_out, bus.overflow, bus.zero}, 32'h0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_abort_in_ready", 32'(bus.in_ready), 32'h1);
    run_op(32'h0000_0100, 32'h0000_0001, 0, g);
    chk("t6_result", g.res, 32'h0000_00FF);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: ra = {1'b1, 31'($urandom_range(0, 3))};
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        default: ;
      endcase
      run_op(ra, rb, $urandom_range(0, 3), g);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
